// File: rtl/rr_mux_arbiter_pkg.sv
// rtl/rr_mux_arbiter_pkg.sv - state type and default sizes for rr_mux_arbiter
`include "mux_defs.vh"

package rr_mux_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = `MUX_ST_IDLE,
    ST_BUSY = `MUX_ST_BUSY
  } state_t;

  localparam int DEF_N = `MUX_DEF_N;
  localparam int DEF_W = `MUX_DEF_W;

endpackage

// File: rtl/mux_defs.vh
// rtl/mux_defs.vh - shared state encodings and default sizing for rr_mux_arbiter
`ifndef MUX_DEFS_VH
`define MUX_DEFS_VH
`define MUX_ST_IDLE 1'b0
`define MUX_ST_BUSY 1'b1
`define MUX_DEF_N 8
`define MUX_DEF_W 8
`endif

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first unmasked req at or above ptr, wrapping
module rr_pick #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic          found,
  output logic [SW-1:0] index
);

  logic [N-1:0]  eff;
  logic [SW-1:0] cand;

  assign eff = req & ~mask;

  // N is a power of two, so SW-bit addition wraps N-1 back to 0 for free.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr + SW'(k);
      if (!found && eff[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin N:1 word arbiter with registered grant/sel/data and backpressure
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] in_data,
  input  logic           out_ready,
  output logic [N-1:0]   grant,
  output logic [SW-1:0]  sel,
  output logic           out_valid,
  output logic [W-1:0]   out_data
);

  state_t        state, state_next;
  logic [SW-1:0] ptr;
  logic [SW-1:0] pick_ptr;
  logic [N-1:0]  pick_mask;
  logic          pick_found;
  logic [SW-1:0] pick_idx;
  logic          load, clear;
  logic [W-1:0]  words [N];

  for (genvar i = 0; i < N; i++) begin : g_words
    assign words[i] = in_data[i*W +: W];
  end

  // On completion, arbitrate from the slot after the winner with the winner masked out.
  assign pick_ptr  = (state == ST_BUSY) ? SW'(sel + 1'b1) : ptr;
  assign pick_mask = (state == ST_BUSY) ? grant : '0;

  rr_pick #(.N(N), .SW(SW)) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .mask  (pick_mask),
    .found (pick_found),
    .index (pick_idx)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    clear      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          load       = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (out_ready) begin
          if (pick_found) begin
            load = 1'b1;
          end else begin
            clear      = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      grant    <= '0;
      sel      <= '0;
      out_data <= '0;
    end else begin
      state <= state_next;
      if (state == ST_BUSY && out_ready) begin
        ptr <= SW'(sel + 1'b1);
      end
      if (load) begin
        grant    <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
        sel      <= pick_idx;
        out_data <= words[pick_idx];
      end else if (clear) begin
        grant <= '0;
      end
    end
  end

  assign out_valid = (state == ST_BUSY);

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 SHALL have parameter N, default 8, meaning number of requesters (power of two, 2..8).
REQ-002 SHALL have parameter W, default 8, meaning data width per requester.
REQ-003 SHALL have localparam SW = log2(N), meaning select width (3 at default).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req  input  N  request per requester; bit i held high until requester i is accepted.
REQ-007 in_data  input  N*W  requester data; slice i = in_data[i*W +: W].
REQ-008 out_ready  input  1  downstream accepts out_data when high with out_valid.
REQ-009 grant  output  N  one-hot registered grant; all-zero when idle.
REQ-010 sel  output  SW  registered index of granted requester, driving the shared mux select.
REQ-011 out_valid  output  1  out_data holds a valid word.
REQ-012 out_data  output  W  registered copy of the granted requester's slice.

Function
REQ-013 SHALL implement two states: IDLE (out_valid=0) and BUSY (out_valid=1).
REQ-014 In IDLE with any req bit high, SHALL pick the first high req bit searching upward from ptr, wrapping N-1 to 0.
- Next edge: grant=onehot(pick), sel=pick, out_data=in_data slice pick, out_valid=1; state BUSY.
REQ-015 Latency SHALL be one cycle from req sampled high in IDLE to out_valid high.
REQ-016 In BUSY with out_ready=0, grant, sel, out_data and out_valid SHALL hold stable.
REQ-017 In BUSY with out_ready=1, the transfer completes and ptr SHALL become (sel+1) mod N.
- The accepted requester sees grant[i] & out_valid & out_ready as its accept strobe.
REQ-018 On completion, if any req bit other than the accepted one is high, SHALL arbitrate in the same cycle using the updated pointer and stay BUSY; back-to-back throughput is one word per cycle.
REQ-019 On completion with no other req bit high, SHALL clear grant, clear out_valid and enter IDLE.
- sel and out_data hold their last values.
REQ-020 The accepted requester's req bit SHALL be masked during the completion-cycle arbitration, so a requester never wins twice consecutively while others wait.
REQ-021 Deassertion of req[i] while i is granted SHALL be ignored; the latched word still completes.
REQ-022 in_data changes after capture SHALL NOT affect out_data.
REQ-023 With all N requesters continuously requesting, grants SHALL rotate 0,1,...,N-1,0 with no starvation.
- Worst-case wait is N-1 transfers.
REQ-024 grant SHALL be one-hot or zero at every edge; grant nonzero SHALL imply out_valid=1.

Reset
REQ-025 With rst_n low at an edge, SHALL set grant=0, sel=0, out_data=0, out_valid=0, ptr=0 and state=IDLE.
REQ-026 Reset mid-transfer SHALL drop the in-flight word; no accept strobe is generated for it.
REQ-027 The first arbitration after reset SHALL start its search at index 0.

Structure
REQ-028 A shared include file mux_defs.vh SHALL hold the state encodings (IDLE=1'b0, BUSY=1'b1) and the default N/W values.
REQ-029 Round-robin selection SHALL live in one combinational sub-module rr_pick.
- Inputs: req, ptr, mask.
- Outputs: found, index.
REQ-030 The data-select path SHALL be a parameterised N:1 word mux indexed by the next sel value, registered into out_data.

Verification
REQ-031 Single request: req=8'b0000_0100, in_data slice2=8'hA5, out_ready=1 -> next cycle grant=8'b0000_0100, sel=2, out_data=8'hA5, out_valid=1 for exactly one cycle; then IDLE.
REQ-032 All requesting: req=8'hFF held, out_ready=1 from reset -> sel sequence 0,1,2,...,7,0 on consecutive cycles, out_valid continuously high.
REQ-033 Backpressure: grant to 5 with out_ready=0 for 4 cycles while in_data slice5 changes -> out_data, sel=5 and grant stable; accept on the 5th cycle.
REQ-034 Pointer wrap: last accept sel=7, then req=8'b1000_0001 -> next grant index 0; after that accept, grant index 7.
REQ-035 Reset mid-transfer: rst_n=0 for one edge while BUSY with out_ready=0 -> all outputs 0 next cycle; req=8'b0000_1000 afterwards -> grant index 3.
REQ-036 Assertions for the whole run:
- grant is one-hot or zero.
- grant nonzero implies out_valid.
- sel equals the index of grant whenever out_valid=1.
